// File: rtl/apple_spawn_pkg.sv
// Shared types and constants for the apple spawn controller.
package apple_spawn_pkg;
  localparam int         MAX_LENGTH  = 30;
  localparam int         NUM_WALLS   = 25;
  localparam logic [7:0] WALL_UNUSED = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE, S_DRAW, S_LOAD, S_BOUNDS, S_SCAN_BODY, S_SCAN_WALL, S_COMMIT
  } state_e;
endpackage

// File: rtl/apple_spawn_arb.sv
// Two-requester round-robin arbiter; pointer moves past the slot just served.
module apple_spawn_arb (
  input  logic       system_clk,
  input  logic       nreset,
  input  logic [1:0] req,
  input  logic       adv,
  input  logic       adv_slot,
  output logic       gnt_vld,
  output logic       gnt_slot
);
  logic prio_q, prio_d;

  always_comb begin
    prio_d   = adv ? ~adv_slot : prio_q;
    gnt_vld  = |req;
    gnt_slot = (req == 2'b11) ? prio_q : req[1];
  end

  always_ff @(posedge system_clk or negedge nreset)
    if (!nreset) prio_q <= 1'b0;
    else         prio_q <= prio_d;
endmodule

// File: rtl/apple_spawn_ctrl.sv
// Apple placement search: draw a random {y,x}, check bounds, snake body and
// walls one entry per cycle, then commit to the granted slot or give up.
module apple_spawn_ctrl #(
  parameter int         MAX_LENGTH = apple_spawn_pkg::MAX_LENGTH,
  parameter int         NUM_WALLS  = apple_spawn_pkg::NUM_WALLS,
  parameter logic [7:0] MAX_TRIES  = 8'd255
) (
  input  logic                                system_clk,
  input  logic                                nreset,
  input  logic [1:0]                          req,
  input  logic                                two_apple_en,
  input  logic [7:0]                          rnd_in,
  output logic                                rnd_en,
  input  logic [3:0]                          xmin,
  input  logic [3:0]                          xmax,
  input  logic [3:0]                          ymin,
  input  logic [3:0]                          ymax,
  input  logic [$clog2(MAX_LENGTH+1)-1:0]     snake_len,
  input  logic [MAX_LENGTH-1:0][3:0]          snakeArrayX,
  input  logic [MAX_LENGTH-1:0][3:0]          snakeArrayY,
  input  logic [NUM_WALLS-1:0][7:0]           wall_locations,
  output logic [7:0]                          apple_loc0,
  output logic [7:0]                          apple_loc1,
  output logic [1:0]                          ack,
  output logic                                fail,
  output logic                                busy
);
  import apple_spawn_pkg::*;

  localparam int LW = $clog2(MAX_LENGTH+1);
  localparam int WW = (NUM_WALLS > 1) ? $clog2(NUM_WALLS) : 1;
  localparam logic [WW-1:0] WLAST = WW'(NUM_WALLS-1);

  state_e        state_q, state_d;
  logic          slot_q, slot_d;
  logic [7:0]    cand_q, cand_d, try_q, try_d, try_inc;
  logic [7:0]    loc0_q, loc0_d, loc1_q, loc1_d;
  logic [LW-1:0] bidx_q, bidx_d;
  logic [WW-1:0] widx_q, widx_d;
  logic [1:0]    ack_q, ack_d, req_m, slot_oh;
  logic          fail_q, fail_d;
  logic          gnt_vld, gnt_slot, adv, oob, body_hit, wall_hit, reject;
  logic [7:0]    other_loc, wall_e;

  assign req_m = req & {two_apple_en, 1'b1};

  apple_spawn_arb u_arb (
    .system_clk (system_clk),
    .nreset     (nreset),
    .req        (req_m),
    .adv        (adv),
    .adv_slot   (slot_q),
    .gnt_vld    (gnt_vld),
    .gnt_slot   (gnt_slot)
  );

  always_comb begin
    other_loc = slot_q ? loc0_q : loc1_q;
    oob = (cand_q[3:0] < xmin) || (cand_q[3:0] > xmax) ||
          (cand_q[7:4] < ymin) || (cand_q[7:4] > ymax) ||
          (two_apple_en && (cand_q == other_loc));
    body_hit = ({snakeArrayY[bidx_q], snakeArrayX[bidx_q]} == cand_q);
    wall_e   = wall_locations[widx_q];
    wall_hit = (wall_e != WALL_UNUSED) && (wall_e == cand_q);
    slot_oh  = slot_q ? 2'b10 : 2'b01;
    try_inc  = try_q + 8'd1;
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cand_d  = cand_q;
    try_d   = try_q;
    loc0_d  = loc0_q;
    loc1_d  = loc1_q;
    bidx_d  = bidx_q;
    widx_d  = widx_q;
    ack_d   = 2'b00;
    fail_d  = 1'b0;
    adv     = 1'b0;
    reject  = 1'b0;
    case (state_q)
      S_IDLE: if (gnt_vld) begin
        slot_d  = gnt_slot;
        try_d   = 8'd0;
        bidx_d  = '0;
        widx_d  = '0;
        state_d = S_DRAW;
      end
      S_DRAW: state_d = S_LOAD;
      S_LOAD: begin
        cand_d  = rnd_in;
        state_d = S_BOUNDS;
      end
      S_BOUNDS:
        if (oob)                 reject  = 1'b1;
        else if (snake_len == 0) state_d = S_SCAN_WALL;
        else                     state_d = S_SCAN_BODY;
      S_SCAN_BODY:
        if (body_hit) reject = 1'b1;
        else if (bidx_q == snake_len - 1'b1) begin
          bidx_d  = '0;
          state_d = S_SCAN_WALL;
        end else bidx_d = bidx_q + 1'b1;
      S_SCAN_WALL:
        if (wall_hit) reject = 1'b1;
        else if (widx_q == WLAST) begin
          if (slot_q) loc1_d = cand_q;
          else        loc0_d = cand_q;
          ack_d   = slot_oh;
          widx_d  = '0;
          state_d = S_COMMIT;
        end else widx_d = widx_q + 1'b1;
      S_COMMIT: begin
        adv     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A give-up commits with ack+fail but leaves the location untouched.
    if (reject) begin
      bidx_d = '0;
      widx_d = '0;
      try_d  = try_inc;
      if (try_inc == MAX_TRIES) begin
        ack_d   = slot_oh;
        fail_d  = 1'b1;
        state_d = S_COMMIT;
      end else state_d = S_DRAW;
    end
  end

  always_ff @(posedge system_clk or negedge nreset)
    if (!nreset) begin
      state_q <= S_IDLE;
      slot_q  <= 1'b0;
      cand_q  <= 8'h00;
      try_q   <= 8'h00;
      loc0_q  <= 8'h55;
      loc1_q  <= 8'h00;
      bidx_q  <= '0;
      widx_q  <= '0;
      ack_q   <= 2'b00;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cand_q  <= cand_d;
      try_q   <= try_d;
      loc0_q  <= loc0_d;
      loc1_q  <= loc1_d;
      bidx_q  <= bidx_d;
      widx_q  <= widx_d;
      ack_q   <= ack_d;
      fail_q  <= fail_d;
    end

  assign rnd_en     = (state_q == S_DRAW);
  assign busy       = (state_q != S_IDLE);
  assign ack        = ack_q;
  assign fail       = fail_q;
  assign apple_loc0 = loc0_q;
  assign apple_loc1 = loc1_q;
endmodule

// File: tb/tb_apple_spawn_ctrl.sv
// Directed and random spawn searches checked against a rule-level model.
module tb_apple_spawn_ctrl;
  localparam int ML = 30;
  localparam int NW = 25;

  logic                system_clk = 1'b0;
  logic                nreset = 1'b0;
  logic [1:0]          req = 2'b00;
  logic                two_apple_en = 1'b0;
  logic [7:0]          rnd_in = 8'h00;
  logic                rnd_en;
  logic [3:0]          xmin = 4'd1, xmax = 4'd14, ymin = 4'd1, ymax = 4'd14;
  logic [4:0]          snake_len = 5'd3;
  logic [ML-1:0][3:0]  sx = '0, sy = '0;
  logic [NW-1:0][7:0]  walls = '1;
  logic [7:0]          apple_loc0, apple_loc1;
  logic [1:0]          ack;
  logic                fail, busy;

  apple_spawn_ctrl dut (
    .system_clk(system_clk), .nreset(nreset), .req(req), .two_apple_en(two_apple_en),
    .rnd_in(rnd_in), .rnd_en(rnd_en), .xmin(xmin), .xmax(xmax), .ymin(ymin), .ymax(ymax),
    .snake_len(snake_len), .snakeArrayX(sx), .snakeArrayY(sy), .wall_locations(walls),
    .apple_loc0(apple_loc0), .apple_loc1(apple_loc1), .ack(ack), .fail(fail), .busy(busy)
  );

  always #5 system_clk = ~system_clk;

  int n_chk = 0, n_fail = 0;
  logic [7:0] cq[$];
  logic [7:0] loc_m[2];
  bit ptr_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge system_clk);
    nreset = 1'b0; req = 2'b00;
    repeat (2) @(negedge system_clk);
    nreset = 1'b1;
    loc_m[0] = 8'h55; loc_m[1] = 8'h00; ptr_m = 1'b0;
  endtask

  function automatic bit free_of_obstacles(input logic [7:0] c, input logic [7:0] other,
                                           output int cost);
    if (c[3:0] < xmin || c[3:0] > xmax || c[7:4] < ymin || c[7:4] > ymax ||
        (two_apple_en && c == other)) begin
      cost = 3; return 0;
    end
    for (int k = 0; k < int'(snake_len); k++)
      if ({sy[k], sx[k]} == c) begin cost = 4 + k; return 0; end
    for (int w = 0; w < NW; w++)
      if (walls[w] != 8'hFF && walls[w] == c) begin cost = 4 + int'(snake_len) + w; return 0; end
    cost = 4 + int'(snake_len) + NW;
    return 1;
  endfunction

  // Candidate i is whatever rnd_in shows after the i-th rnd_en strobe.
  task automatic search(input string tag, input logic [1:0] r, input bit hold);
    logic [1:0] rm;
    bit slot, ok, efail;
    int cyc, cost, draws, n, ci;
    logic [7:0] eloc;
    bit got;
    rm = r & {two_apple_en, 1'b1};
    slot = (rm == 2'b11) ? ptr_m : rm[1];
    while (cq.size() < 255) cq.push_back(8'hFF);
    cyc = 0; draws = 0; ok = 0; eloc = 8'h00;
    for (int i = 0; i < 255 && !ok; i++) begin
      draws++;
      ok = free_of_obstacles(cq[i], loc_m[~slot], cost);
      cyc += cost;
      if (ok) eloc = cq[i];
    end
    efail = !ok;
    if (efail) cyc += 1;
    else loc_m[slot] = eloc;
    ptr_m = ~slot;

    @(negedge system_clk);
    chk({tag, ":idle"}, busy, 1'b0);
    req = r;
    n = 0; ci = 0; got = 0;
    while (n < cyc + 50 && !got) begin
      @(negedge system_clk);
      n++;
      if (n == 1) chk({tag, ":busy"}, busy, 1'b1);
      if (rnd_en) begin rnd_in = (ci < cq.size()) ? cq[ci] : 8'h00; ci++; end
      if (ack != 2'b00) got = 1;
    end
    chk({tag, ":latency"}, n, cyc);
    chk({tag, ":ack"}, ack, slot ? 2'b10 : 2'b01);
    chk({tag, ":fail"}, fail, efail);
    chk({tag, ":draws"}, ci, draws);
    chk({tag, ":loc0"}, apple_loc0, loc_m[0]);
    chk({tag, ":loc1"}, apple_loc1, loc_m[1]);
    req = hold ? (req & ~ack) : 2'b00;
    cq.delete();
  endtask

  initial begin
    do_reset();
    #1;
    chk("rst:loc0", apple_loc0, 8'h55);
    chk("rst:loc1", apple_loc1, 8'h00);
    chk("rst:busy", busy, 1'b0);
    chk("rst:ack", ack, 2'b00);
    chk("rst:fail", fail, 1'b0);
    chk("rst:rnd_en", rnd_en, 1'b0);

    sx[0] = 4'd1; sy[0] = 4'd1;
    sx[1] = 4'd2; sy[1] = 4'd1;
    sx[2] = 4'd3; sy[2] = 4'd1;
    walls = '1;
    cq = '{8'h77};
    search("first_try", 2'b01, 0);
    chk("first_try:abs", apple_loc0, 8'h77);

    cq = '{8'h0F, 8'h33};
    search("oob_once", 2'b01, 0);

    walls[24] = 8'h45;
    cq = '{8'h13, 8'h45, 8'h66};
    search("body_wall", 2'b01, 0);
    chk("body_wall:abs", apple_loc0, 8'h66);
    walls = '1;

    do_reset();
    two_apple_en = 1'b1;
    cq = '{8'h22};
    search("rr_first", 2'b11, 1);
    cq = '{8'h22, 8'h3A};
    search("rr_second", 2'b10, 1);
    chk("rr:distinct", apple_loc1 != apple_loc0, 1'b1);
    req = 2'b00;

    two_apple_en = 1'b0;
    @(negedge system_clk);
    req = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(negedge system_clk);
      chk("masked:busy", busy, 1'b0);
      chk("masked:ack", ack, 2'b00);
    end
    req = 2'b00;

    for (int it = 0; it < 20; it++) begin
      logic [1:0] r;
      two_apple_en = 1'($urandom_range(0, 1));
      r = two_apple_en ? 2'($urandom_range(1, 3)) : 2'b01;
      xmin = 4'($urandom_range(0, 3));  xmax = 4'($urandom_range(10, 15));
      ymin = 4'($urandom_range(0, 3));  ymax = 4'($urandom_range(10, 15));
      snake_len = 5'($urandom_range(0, 6));
      for (int k = 0; k < ML; k++) begin sx[k] = 4'($urandom); sy[k] = 4'($urandom); end
      for (int w = 0; w < NW; w++) walls[w] = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'hFF;
      for (int i = 0; i < 255; i++) cq.push_back(8'($urandom));
      search("random", r, 0);
    end

    do_reset();
    two_apple_en = 1'b0;
    xmin = 4'd1; xmax = 4'd14; ymin = 4'd1; ymax = 4'd14; snake_len = 5'd3;
    for (int i = 0; i < 255; i++) cq.push_back(8'h0F);
    search("give_up", 2'b01, 0);
    chk("give_up:abs", apple_loc0, 8'h55);

    do_reset();
    cq = '{8'h77};
    @(negedge system_clk);
    req = 2'b01;
    for (int n = 1; n <= 12; n++) begin
      @(negedge system_clk);
      if (rnd_en) rnd_in = 8'h77;
      chk("midreset:noack", ack, 2'b00);
    end
    nreset = 1'b0; req = 2'b00;
    #1;
    chk("midreset:busy", busy, 1'b0);
    chk("midreset:ack", ack, 2'b00);
    chk("midreset:rnd_en", rnd_en, 1'b0);
    chk("midreset:loc0", apple_loc0, 8'h55);
    chk("midreset:loc1", apple_loc1, 8'h00);
    repeat (2) @(negedge system_clk);
    nreset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge system_clk);
      chk("post_reset:ack", ack, 2'b00);
      chk("post_reset:busy", busy, 1'b0);
    end
    chk("post_reset:loc0", apple_loc0, 8'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
